// File: rtl/relay_station_sink.sv
// FWFT read-side consumer: converts empty_n/read/dout into a registered valid/ready stream
// through a two-entry skid buffer. Define RELAY_STATION_SINK_STATS_EN for beat/stall/starve counters.
module relay_station_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  if_read_ce,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef RELAY_STATION_SINK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_beats,
  output logic [CNT_WIDTH-1:0]  stat_stalls,
  output logic [CNT_WIDTH-1:0]  stat_starve
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] skid;
  logic                  pop, take;

  assign pop        = if_empty_n & if_read;
  assign take       = m_valid & m_ready;
  assign if_read_ce = 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (pop) state_nx = ONE;
      ONE: begin
        if (pop && !take)      state_nx = FULL;
        else if (!pop && take) state_nx = EMPTY;
      end
      FULL:    if (take) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // if_read is derived from the next state only, so m_ready never reaches it combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      if_read   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      skid      <= '0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nx;
      if_read   <= (state_nx != FULL);
      m_valid   <= (state_nx != EMPTY);
      occupancy <= state_nx;
      case (state)
        EMPTY: if (pop) m_data <= if_dout;
        ONE: begin
          if (pop && take) m_data <= if_dout;
          else if (pop)    skid   <= if_dout;
        end
        FULL:    if (take) m_data <= skid;
        default: ;
      endcase
    end
  end

`ifdef RELAY_STATION_SINK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
      stat_starve <= '0;
    end else begin
      if (take)                    stat_beats  <= stat_beats + CNT_WIDTH'(1);
      if (m_valid && !m_ready)     stat_stalls <= stat_stalls + CNT_WIDTH'(1);
      if (!m_valid && !if_empty_n) stat_starve <= stat_starve + CNT_WIDTH'(1);
    end
  end
`else
  // CNT_WIDTH only sizes the statistics counters; nothing to build without them
  if (CNT_WIDTH < 1) begin : g_no_stats
  end
`endif

endmodule
